result_router: RTL and testbench
================================

RESULT_ROUTER -- requirements
Module: result_router

Interface
REQ-001 Parameter DATA_W, default 32: width of every data path.
REQ-002 Parameter N_DEST, default 3: number of destination channels (0=GPR, 1=RAM, 2=PC).
REQ-003 Parameter DEPTH, default 4: input FIFO entries; power of two, >=2.
REQ-004 Derived DEST_W = max(1, clog2(N_DEST)); LVL_W = clog2(DEPTH)+1.
REQ-005 One clock; reset is asynchronous and active-high; ports clk and rst.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 flush  in  1  synchronous discard of all buffered results.
REQ-009 in_valid  in  1  producer (ALU) offers a result.
REQ-010 in_ready  out  1  router accepts; transfer when in_valid && in_ready.
REQ-011 in_dest  in  DEST_W  destination index of offered result.
REQ-012 in_data  in  DATA_W  result value.
REQ-013 out_valid  out  N_DEST  per-channel valid, at most one bit set.
REQ-014 out_ready  in  N_DEST  per-channel consumer ready.
REQ-015 out_data  out  N_DEST*DATA_W  channel d at bits [d*DATA_W +: DATA_W].
REQ-016 err_cnt  out  8  saturating count of out-of-range destinations.
REQ-017 level  out  LVL_W  current FIFO occupancy.

Function
REQ-018 FIFO push on in_valid && in_ready; in_ready = (level != DEPTH), from registered state only; no push when full, even with a same-cycle pop.
REQ-019 Output stage FSM states EMPTY and HOLD; EMPTY->HOLD when FIFO non-empty; HOLD->HOLD on handshake if FIFO non-empty (reload next entry); HOLD->EMPTY on handshake with FIFO empty; HOLD without handshake holds data and channel stable.
REQ-020 Handshake on channel d: out_valid[d] && out_ready[d]; ready on non-selected channels is ignored.
REQ-021 Latency: result accepted at edge k with FIFO empty and stage EMPTY appears on out_valid after edge k+1; sustained throughput 1 result/cycle when the selected out_ready stays high.
REQ-022 In EMPTY all out_valid low and all out_data zero; in HOLD only the selected channel carries data; all other channels' out_data are zero.
REQ-023 in_dest >= N_DEST routes to channel 0 (GPR) and increments err_cnt at push; err_cnt saturates at 255.
REQ-024 FIFO pointers wrap modulo DEPTH; level ranges 0..DEPTH.
REQ-025 flush: next edge level=0, stage EMPTY, pointers zero; push in the flush cycle is dropped; a handshake in the flush cycle still completes; err_cnt unchanged.
REQ-026 Order is preserved across channels: results leave in acceptance order.

Reset
REQ-027 rst asserted: level=0, pointers=0, stage EMPTY, out_valid=0, out_data=0, err_cnt=0, in_ready=0 while rst is high.
REQ-028 Reset mid-transfer discards every buffered and held result; no partial output after release; in_ready=1 on the first edge after release.

Structure
REQ-029 Shared package cpu_pkg holds DEST_GPR/DEST_RAM/DEST_PC constants and the router state enum (EMPTY, HOLD).
REQ-030 FIFO is one sub-module route_fifo (parameters DATA_W+DEST_W, DEPTH), instantiated once; FSM and output steering live in result_router.

Verification
REQ-031 Push 0x11 dest 1, out_ready=all 1 -> out_valid=3'b010, RAM data=0x11 one cycle after accept; GPR/PC data=0.
REQ-032 out_ready=0, push 5 results (DEPTH=4) -> in_ready low after 4 FIFO plus 1 held; level=4; releasing ready drains in order, 1/cycle.
REQ-033 Push dest 3 (N_DEST=3) value 0xAB -> delivered on GPR channel, err_cnt=1; 300 such pushes -> err_cnt=255.
REQ-034 FIFO full plus HOLD, assert flush with in_valid=1 -> next cycle level=0, out_valid=0, pushed value never appears.
REQ-035 Assert rst while HOLD on PC with data 0xDEAD -> out_valid=0, out_data=0 immediately; first output after release is a fresh push.
REQ-036 Alternate dest 0,1,2 with ready toggling per channel -> data held stable while not ready; no loss, no duplication.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: result destination channel indices and the
// output-stage state encoding of the result router.
package cpu_pkg;

    localparam int DEST_GPR = 0;
    localparam int DEST_RAM = 1;
    localparam int DEST_PC  = 2;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } router_state_t;

endpackage

// File: rtl/route_fifo.sv
// Circular-buffer FIFO holding routed results; pointers wrap modulo DEPTH
// (power of two), occupancy counts 0..DEPTH. Flush clears it synchronously.
module route_fifo #(
    parameter int  WIDTH = 34,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage has no reset; entries are only read when level says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));

endmodule

// File: rtl/result_router.sv
// Buffers ALU results and steers each, in acceptance order, to its destination
// channel (GPR/RAM/PC) through a single-entry holding stage.
module result_router
    import cpu_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  N_DEST = 3,
    parameter int  DEPTH  = 4,
    localparam int DEST_W = (N_DEST > 1) ? $clog2(N_DEST) : 1,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DEST_W-1:0]        in_dest,
    input  logic [DATA_W-1:0]        in_data,
    output logic [N_DEST-1:0]        out_valid,
    input  logic [N_DEST-1:0]        out_ready,
    output logic [N_DEST*DATA_W-1:0] out_data,
    output logic [7:0]               err_cnt,
    output logic [LVL_W-1:0]         level
);

    router_state_t       state;
    logic [DEST_W-1:0]   hold_dest;
    logic [DATA_W-1:0]   hold_data;

    logic                fifo_empty;
    logic                fifo_full;
    logic [DEST_W+DATA_W-1:0] fifo_rdata;
    logic                dest_bad;
    logic [DEST_W-1:0]   dest_routed;
    logic                push;
    logic                pop;
    logic                handshake;
    logic                load;

    assign in_ready    = !rst && !fifo_full;
    assign dest_bad    = (int'(in_dest) >= N_DEST);
    assign dest_routed = dest_bad ? DEST_W'(DEST_GPR) : in_dest;
    assign push        = in_valid && in_ready && !flush;

    // Only the selected channel's ready matters because out_valid is one-hot.
    assign handshake = |(out_valid & out_ready);
    assign load      = !fifo_empty && ((state == EMPTY) || handshake);
    assign pop       = load && !flush;

    route_fifo #(
        .WIDTH (DEST_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({dest_routed, in_data}),
        .rdata (fifo_rdata),
        .level (level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            hold_dest <= '0;
            hold_data <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            hold_dest <= '0;
            hold_data <= '0;
        end else if (load) begin
            state     <= HOLD;
            hold_dest <= fifo_rdata[DEST_W+DATA_W-1:DATA_W];
            hold_data <= fifo_rdata[DATA_W-1:0];
        end else if (handshake) begin
            state <= EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (push && dest_bad && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        if (state == HOLD) begin
            for (int d = 0; d < N_DEST; d++) begin
                if (hold_dest == DEST_W'(d)) begin
                    out_valid[d]                   = 1'b1;
                    out_data[d*DATA_W +: DATA_W]   = hold_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_router.sv
// Directed self-checking bench for result_router with default parameters
// (DATA_W=32, N_DEST=3, DEPTH=4).
module tb_result_router;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_dest;
    logic [31:0] in_data;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [95:0] out_data;
    logic [7:0]  err_cnt;
    logic [2:0]  level;

    int tests;
    int fails;

    typedef struct {
        logic [1:0]  dest;
        logic [31:0] data;
    } item_t;

    result_router dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_cnt   (err_cnt),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] exp_data(input logic [1:0] d, input logic [31:0] v);
        logic [95:0] r;
        r = '0;
        r[int'(d)*32 +: 32] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] d, input logic [31:0] v);
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++; if (out_valid !== 3'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 000", out_valid); end
        tests++; if (out_data !== 96'b0) begin fails++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        tests++; if (level !== 3'd0)     begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
        tests++; if (err_cnt !== 8'd0)   begin fails++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        rst = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 3'b111;
        push_one(2'd1, 32'h11);
        tests++; if (level !== 3'd1)     begin fails++; $display("FAIL single_level got %0d exp 1", level); end
        tests++; if (out_valid !== 3'b0) begin fails++; $display("FAIL single_early got %b exp 000", out_valid); end
        tick();
        tests++; if (out_valid !== 3'b010) begin fails++; $display("FAIL single_valid got %b exp 010", out_valid); end
        tests++; if (out_data !== exp_data(2'd1, 32'h11)) begin fails++; $display("FAIL single_data got %h exp %h", out_data, exp_data(2'd1, 32'h11)); end
        tick();
        tests++; if (out_valid !== 3'b0) begin fails++; $display("FAIL single_done got %b exp 000", out_valid); end
    endtask

    task automatic fill_five(input logic [31:0] base, input bit rotate);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_dest  = rotate ? 2'(i % 3) : 2'd2;
            in_data  = base + 32'(i);
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready[%0d] got %b exp 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 3'b000;
        fill_five(32'h100, 1'b1);
        tests++; if (in_ready !== 1'b0)    begin fails++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
        tests++; if (level !== 3'd4)       begin fails++; $display("FAIL bp_level got %0d exp 4", level); end
        tests++; if (out_valid !== 3'b001) begin fails++; $display("FAIL bp_hold got %b exp 001", out_valid); end
        out_ready = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (out_valid !== (3'b001 << (i % 3)) || out_data !== exp_data(2'(i % 3), 32'h100 + 32'(i))) begin
                fails++;
                $display("FAIL bp_drain[%0d] got %b/%h exp %b/%h", i, out_valid, out_data,
                         3'b001 << (i % 3), exp_data(2'(i % 3), 32'h100 + 32'(i)));
            end
            tick();
        end
        tests++; if (out_valid !== 3'b0 || level !== 3'd0) begin fails++; $display("FAIL bp_empty got %b/%0d exp 000/0", out_valid, level); end
    endtask

    task automatic test_flush();
        out_ready = 3'b000;
        fill_five(32'h400, 1'b0);
        in_valid = 1'b1; in_dest = 2'd3; in_data = 32'hF1F1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tests++; if (level !== 3'd0)     begin fails++; $display("FAIL flush_level got %0d exp 0", level); end
        tests++; if (out_valid !== 3'b0 || out_data !== 96'b0) begin fails++; $display("FAIL flush_out got %b/%h exp 000/0", out_valid, out_data); end
        in_valid = 1'b1; in_dest = 2'd3; in_data = 32'hF2F2; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tests++; if (level !== 3'd0)   begin fails++; $display("FAIL flush_drop_level got %0d exp 0", level); end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL flush_err_cnt got %0d exp 0", err_cnt); end
        out_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (out_valid !== 3'b0) begin fails++; $display("FAIL flush_ghost[%0d] got %b exp 000", i, out_valid); end
        end
    endtask

    task automatic test_err_cnt();
        int accepted;
        int budget;
        out_ready = 3'b111;
        push_one(2'd3, 32'hAB);
        tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL err_one got %0d exp 1", err_cnt); end
        tick();
        tests++; if (out_valid !== 3'b001 || out_data !== exp_data(2'd0, 32'hAB)) begin fails++; $display("FAIL err_route got %b/%h exp 001/%h", out_valid, out_data, exp_data(2'd0, 32'hAB)); end
        accepted = 0;
        budget   = 0;
        in_valid = 1'b1; in_dest = 2'd3;
        while (accepted < 300 && budget < 1000) begin
            in_data = 32'(accepted);
            if (in_ready) accepted++;
            budget++;
            tick();
        end
        in_valid = 1'b0;
        tests++; if (accepted != 300)    begin fails++; $display("FAIL err_timeout got %0d exp 300", accepted); end
        tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL err_sat got %0d exp 255", err_cnt); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 3'b000;
        push_one(2'd2, 32'hDEAD);
        push_one(2'd0, 32'hBEEF);
        tests++; if (out_valid !== 3'b100 || out_data !== exp_data(2'd2, 32'hDEAD)) begin fails++; $display("FAIL rmid_hold got %b/%h exp 100/%h", out_valid, out_data, exp_data(2'd2, 32'hDEAD)); end
        #2 rst = 1'b1;
        #1;
        tests++; if (out_valid !== 3'b0 || out_data !== 96'b0) begin fails++; $display("FAIL rmid_out got %b/%h exp 000/0", out_valid, out_data); end
        tests++; if (in_ready !== 1'b0 || level !== 3'd0 || err_cnt !== 8'd0) begin fails++; $display("FAIL rmid_state got %b/%0d/%0d exp 0/0/0", in_ready, level, err_cnt); end
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b exp 1", in_ready); end
        out_ready = 3'b111;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (out_valid !== 3'b0) begin fails++; $display("FAIL rmid_stale[%0d] got %b exp 000", i, out_valid); end
        end
        push_one(2'd1, 32'h55);
        tick();
        tests++; if (out_valid !== 3'b010 || out_data !== exp_data(2'd1, 32'h55)) begin fails++; $display("FAIL rmid_fresh got %b/%h exp 010/%h", out_valid, out_data, exp_data(2'd1, 32'h55)); end
        tick();
    endtask

    task automatic test_alternate();
        logic [2:0] pat [8];
        item_t       q [$];
        item_t       it;
        logic [2:0]  pv;
        logic [95:0] pd;
        bit          stalled;
        bit          hs;
        bit          will_push;
        int          sent;
        int          rx;
        int          cyc;
        pat = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111};
        sent = 0; rx = 0; cyc = 0; stalled = 1'b0;
        pv = '0; pd = '0;
        while ((sent < 9 || q.size() != 0) && cyc < 200) begin
            out_ready = pat[cyc % 8];
            if (sent < 9) begin
                in_valid = 1'b1;
                in_dest  = 2'(sent % 3);
                in_data  = 32'h300 + 32'(sent);
            end else begin
                in_valid = 1'b0;
            end
            will_push = in_valid && in_ready;
            if (stalled) begin
                tests++;
                if (out_valid !== pv || out_data !== pd) begin
                    fails++;
                    $display("FAIL alt_stable[%0d] got %b/%h exp %b/%h", cyc, out_valid, out_data, pv, pd);
                end
            end
            if (out_valid !== 3'b0) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL alt_extra[%0d] got %b exp 000", cyc, out_valid);
                end else if (out_valid !== (3'b001 << q[0].dest) || out_data !== exp_data(q[0].dest, q[0].data)) begin
                    fails++;
                    $display("FAIL alt_order[%0d] got %b/%h exp %b/%h", cyc, out_valid, out_data,
                             3'b001 << q[0].dest, exp_data(q[0].dest, q[0].data));
                end
            end
            hs      = |(out_valid & out_ready);
            stalled = (out_valid != 3'b0) && !hs;
            pv      = out_valid;
            pd      = out_data;
            tick();
            if (hs && q.size() != 0) begin
                void'(q.pop_front());
                rx++;
            end
            if (will_push) begin
                it.dest = 2'(sent % 3);
                it.data = 32'h300 + 32'(sent);
                q.push_back(it);
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests++; if (rx != 9 || q.size() != 0) begin fails++; $display("FAIL alt_count got %0d left %0d exp 9 left 0", rx, q.size()); end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_dest = '0; in_data = '0; out_ready = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_err_cnt();
        test_reset_mid();
        test_alternate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
